// File: rtl/servo_pwm_multi_pkg.sv
// Shared types, default timing constants and saturating width arithmetic
// for the multi-channel servo PWM generator.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_INC = 2'd1,
        PEND_DEC = 2'd2
    } pend_state_t;

    localparam int DEF_NUM_CH       = 2;
    localparam int DEF_CNT_W        = 21;
    localparam int DEF_FRAME_CYCLES = 1000000;
    localparam int DEF_MIN_PULSE    = 5000;
    localparam int DEF_MAX_PULSE    = 150000;
    localparam int DEF_CENTER_PULSE = 75000;
    localparam int DEF_STEP         = 450;

    // One extra bit of headroom so the sum can never wrap before the clamp.
    function automatic logic [31:0] clamp_add(input logic [31:0] value,
                                              input logic [31:0] step,
                                              input logic [31:0] max_value);
        logic [32:0] sum;
        sum = {1'b0, value} + {1'b0, step};
        return (sum > {1'b0, max_value}) ? max_value : sum[31:0];
    endfunction

    function automatic logic [31:0] clamp_sub(input logic [31:0] value,
                                              input logic [31:0] step,
                                              input logic [31:0] min_value);
        logic [32:0] floor_value;
        floor_value = {1'b0, min_value} + {1'b0, step};
        return ({1'b0, value} < floor_value) ? min_value : (value - step);
    endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Request/pulse bundle between the key or tracker logic and the servo
// generator; the generator side uses the slave modport.
interface servo_pwm_multi_if
    import servo_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
);
    logic [NUM_CH-1:0]       inc;
    logic [NUM_CH-1:0]       dec;
    logic [NUM_CH-1:0]       pwm;
    logic                    frame_start;
    logic [NUM_CH*CNT_W-1:0] width;

    modport master (
        output inc,
        output dec,
        input  pwm,
        input  frame_start,
        input  width
    );

    modport slave (
        input  inc,
        input  dec,
        output pwm,
        output frame_start,
        output width
    );
endinterface

// File: rtl/servo_pwm_multi_channel.sv
// One servo channel: request synchronisers and edge detectors, pending
// step FSM, frame-committed width register and the registered pulse output.
module servo_channel
    import servo_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int MIN_PULSE    = DEF_MIN_PULSE,
    parameter int MAX_PULSE    = DEF_MAX_PULSE,
    parameter int CENTER_PULSE = DEF_CENTER_PULSE,
    parameter int STEP         = DEF_STEP
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             commit,
    input  logic [CNT_W-1:0] frame_cnt,
    output logic             pwm,
    output logic [CNT_W-1:0] width
);

    logic [1:0]  inc_sync;
    logic [1:0]  dec_sync;
    logic        inc_hist;
    logic        dec_hist;
    logic        inc_edge;
    logic        dec_edge;
    pend_state_t state;

    assign inc_edge = inc_sync[1] & ~inc_hist;
    assign dec_edge = dec_sync[1] & ~dec_hist;

    // The commit cycle takes priority over any edge arriving with it, so a
    // request landing exactly on the frame boundary is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            inc_sync <= '0;
            dec_sync <= '0;
            inc_hist <= 1'b0;
            dec_hist <= 1'b0;
            state    <= IDLE;
            width    <= CNT_W'(CENTER_PULSE);
            pwm      <= 1'b0;
        end else begin
            inc_sync <= {inc_sync[0], inc};
            dec_sync <= {dec_sync[0], dec};
            inc_hist <= inc_sync[1];
            dec_hist <= dec_sync[1];
            pwm      <= (frame_cnt < width);

            if (commit) begin
                case (state)
                    PEND_INC: width <= CNT_W'(clamp_add(32'(width), 32'(STEP), 32'(MAX_PULSE)));
                    PEND_DEC: width <= CNT_W'(clamp_sub(32'(width), 32'(STEP), 32'(MIN_PULSE)));
                    default:  width <= width;
                endcase
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (inc_edge && !dec_edge) begin
                            state <= PEND_INC;
                        end else if (dec_edge && !inc_edge) begin
                            state <= PEND_DEC;
                        end
                    end
                    PEND_INC: if (dec_edge) state <= IDLE;
                    PEND_DEC: if (inc_edge) state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared frame counter and commit strobe
// driving one independent pulse-width channel per servo header.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int MIN_PULSE    = DEF_MIN_PULSE,
    parameter int MAX_PULSE    = DEF_MAX_PULSE,
    parameter int CENTER_PULSE = DEF_CENTER_PULSE,
    parameter int STEP         = DEF_STEP
) (
    input  logic             Clk,
    input  logic             Reset,
    servo_pwm_multi_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

    if (!(MIN_PULSE >= 1 && MIN_PULSE <= CENTER_PULSE &&
          CENTER_PULSE <= MAX_PULSE && MAX_PULSE < FRAME_CYCLES)) begin : g_bad_pulse
        $error("servo_pwm_multi: pulse limits must satisfy 1 <= MIN <= CENTER <= MAX < FRAME_CYCLES");
    end

    if (longint'(FRAME_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_width
        $error("servo_pwm_multi: FRAME_CYCLES does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0]        frame_cnt;
    logic                    frame_start_r;
    logic                    commit;
    logic [NUM_CH-1:0]       pwm_bits;
    logic [NUM_CH*CNT_W-1:0] width_bits;

    assign commit = (frame_cnt == LAST_CNT);

    // Free-running frame counter; frame_start is registered so it lines up
    // with the first registered pwm high cycle of every channel.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            frame_cnt     <= '0;
            frame_start_r <= 1'b0;
        end else begin
            frame_cnt     <= commit ? '0 : (frame_cnt + CNT_W'(1));
            frame_start_r <= (frame_cnt == '0);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        servo_channel #(
            .CNT_W       (CNT_W),
            .MIN_PULSE   (MIN_PULSE),
            .MAX_PULSE   (MAX_PULSE),
            .CENTER_PULSE(CENTER_PULSE),
            .STEP        (STEP)
        ) u_channel (
            .Clk      (Clk),
            .Reset    (Reset),
            .inc      (bus.inc[c]),
            .dec      (bus.dec[c]),
            .commit   (commit),
            .frame_cnt(frame_cnt),
            .pwm      (pwm_bits[c]),
            .width    (width_bits[c*CNT_W +: CNT_W])
        );
    end

    assign bus.pwm         = pwm_bits;
    assign bus.width       = width_bits;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Frame-by-frame bench for servo_pwm_multi: table vectors drive requests,
// expected widths are queued and compared against measured pulse lengths.
module tb_servo_pwm_multi;

    localparam int NUM_CH       = 2;
    localparam int CNT_W        = 8;
    localparam int FRAME_CYCLES = 100;
    localparam int MIN_PULSE    = 10;
    localparam int MAX_PULSE    = 30;
    localparam int CENTER_PULSE = 20;
    localparam int STEP         = 4;

    typedef struct {
        logic [1:0] inc_a;
        logic [1:0] dec_a;
        int         reps_a;
        logic [1:0] inc_b;
        logic [1:0] dec_b;
        int         offset;
        int         hold;
        int         exp0;
        int         exp1;
    } vec_t;

    typedef struct {
        int w0;
        int w1;
    } exp_t;

    logic Clk;
    logic Reset;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    servo_pwm_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    servo_pwm_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .FRAME_CYCLES(FRAME_CYCLES),
        .MIN_PULSE   (MIN_PULSE),
        .MAX_PULSE   (MAX_PULSE),
        .CENTER_PULSE(CENTER_PULSE),
        .STEP        (STEP)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int width_of(input int c);
        return int'(bus.width[c*CNT_W +: CNT_W]);
    endfunction

    // Called on the frame_start sample; returns on the next frame_start sample.
    task automatic measure_frame(input string tag);
        int   hi[NUM_CH];
        int   w_start[NUM_CH];
        int   gap_err;
        int   extra_fs;
        exp_t e;
        gap_err  = 0;
        extra_fs = 0;
        check_output({tag, " frame_start"}, int'(bus.frame_start), 1);
        for (int c = 0; c < NUM_CH; c++) begin
            hi[c]      = 0;
            w_start[c] = width_of(c);
        end
        for (int i = 0; i < FRAME_CYCLES; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.pwm[c]) begin
                    if (i != hi[c]) gap_err = 1;
                    hi[c]++;
                end
            end
            if (i != 0 && bus.frame_start) extra_fs = 1;
            step_cycles(1);
        end
        check_output({tag, " pulse contiguous"}, gap_err, 0);
        check_output({tag, " single frame_start"}, extra_fs, 0);
        if (exp_q.size() == 0) begin
            check_output({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_output({tag, " pwm0 high cycles"}, hi[0], e.w0);
            check_output({tag, " pwm1 high cycles"}, hi[1], e.w1);
            check_output({tag, " width0"}, w_start[0], e.w0);
            check_output({tag, " width1"}, w_start[1], e.w1);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        step_cycles(v.offset);
        for (int r = 0; r < v.reps_a; r++) begin
            bus.inc = v.inc_a;
            bus.dec = v.dec_a;
            step_cycles(v.hold);
            bus.inc = '0;
            bus.dec = '0;
            if (r < v.reps_a - 1 || (v.inc_b | v.dec_b) != 2'b00) step_cycles(5);
        end
        if ((v.inc_b | v.dec_b) != 2'b00) begin
            bus.inc = v.inc_b;
            bus.dec = v.dec_b;
            step_cycles(v.hold);
            bus.inc = '0;
            bus.dec = '0;
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        exp_q.push_back(exp_t'{v.exp0, v.exp1});
        fork
            measure_frame(tag);
            drive_vec(v);
        join
    endtask

    task automatic wait_frame_start(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 3 * FRAME_CYCLES; i++) begin
            if (bus.frame_start) begin
                found = 1;
                break;
            end
            step_cycles(1);
        end
        check_output({tag, " frame_start seen"}, found, 1);
        if (found == 0) begin
            $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
            $finish;
        end
    endtask

    initial begin
        exp_t e;

        // inc_a dec_a reps inc_b dec_b offset hold exp0 exp1
        vecs.push_back(vec_t'{2'b01, 2'b00, 1, 2'b00, 2'b00, 20, 3, 24, 20});
        vecs.push_back(vec_t'{2'b01, 2'b00, 3, 2'b00, 2'b00, 20, 3, 28, 20});
        vecs.push_back(vec_t'{2'b00, 2'b01, 1, 2'b00, 2'b00, 20, 3, 24, 20});
        vecs.push_back(vec_t'{2'b10, 2'b00, 1, 2'b00, 2'b00, 20, 3, 28, 24});
        vecs.push_back(vec_t'{2'b10, 2'b00, 1, 2'b00, 2'b00, 20, 3, 28, 28});
        vecs.push_back(vec_t'{2'b10, 2'b00, 1, 2'b00, 2'b00, 20, 3, 28, 30});
        vecs.push_back(vec_t'{2'b10, 2'b00, 1, 2'b00, 2'b00, 20, 3, 28, 30});
        vecs.push_back(vec_t'{2'b10, 2'b00, 1, 2'b00, 2'b00, 20, 3, 28, 30});
        vecs.push_back(vec_t'{2'b10, 2'b00, 1, 2'b00, 2'b00, 20, 3, 28, 30});
        vecs.push_back(vec_t'{2'b00, 2'b10, 1, 2'b00, 2'b00, 20, 3, 28, 26});
        vecs.push_back(vec_t'{2'b00, 2'b10, 1, 2'b00, 2'b00, 20, 3, 28, 22});
        vecs.push_back(vec_t'{2'b00, 2'b10, 1, 2'b00, 2'b00, 20, 3, 28, 18});
        vecs.push_back(vec_t'{2'b00, 2'b10, 1, 2'b00, 2'b00, 20, 3, 28, 14});
        vecs.push_back(vec_t'{2'b00, 2'b10, 1, 2'b00, 2'b00, 20, 3, 28, 10});
        vecs.push_back(vec_t'{2'b00, 2'b10, 1, 2'b00, 2'b00, 20, 3, 28, 10});
        vecs.push_back(vec_t'{2'b01, 2'b00, 1, 2'b00, 2'b01, 20, 3, 20, 20});
        vecs.push_back(vec_t'{2'b01, 2'b01, 1, 2'b00, 2'b00, 20, 3, 20, 20});
        vecs.push_back(vec_t'{2'b01, 2'b10, 1, 2'b00, 2'b00, 20, 3, 24, 16});
        vecs.push_back(vec_t'{2'b00, 2'b01, 1, 2'b01, 2'b00, 20, 3, 24, 16});
        vecs.push_back(vec_t'{2'b01, 2'b00, 1, 2'b00, 2'b00, 96, 3, 24, 16});
        vecs.push_back(vec_t'{2'b01, 2'b00, 1, 2'b00, 2'b00, 95, 3, 28, 16});
        vecs.push_back(vec_t'{2'b00, 2'b10, 2, 2'b00, 2'b00, 20, 3, 28, 12});
        vecs.push_back(vec_t'{2'b00, 2'b10, 1, 2'b00, 2'b00, 20, 3, 28, 10});

        Reset   = 1'b0;
        bus.inc = '0;
        bus.dec = '0;
        step_cycles(3);
        check_output("reset pwm", int'(bus.pwm), 0);
        check_output("reset frame_start", int'(bus.frame_start), 0);
        check_output("reset width0", width_of(0), CENTER_PULSE);
        check_output("reset width1", width_of(1), CENTER_PULSE);

        Reset = 1'b1;
        wait_frame_start("release");
        exp_q.push_back(exp_t'{20, 20});

        for (int i = 0; i < 3; i++) apply_stimulus(vecs[i], $sformatf("v%0d", i));

        // A level held across five frames must yield exactly one step.
        bus.inc[0] = 1'b1;
        for (int f = 0; f < 5; f++) begin
            exp_q.push_back(exp_t'{28, 20});
            measure_frame($sformatf("held%0d", f));
        end
        bus.inc[0] = 1'b0;
        exp_q.push_back(exp_t'{28, 20});
        measure_frame("held_release");

        for (int i = 3; i < 15; i++) apply_stimulus(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a 28-cycle pulse on channel 0.
        e = exp_q.pop_front();
        check_output("pre-reset width0", width_of(0), e.w0);
        check_output("pre-reset width1", width_of(1), e.w1);
        step_cycles(10);
        check_output("pre-reset pwm0 high", int'(bus.pwm[0]), 1);
        Reset = 1'b0;
        step_cycles(1);
        check_output("mid-reset pwm", int'(bus.pwm), 0);
        check_output("mid-reset width0", width_of(0), CENTER_PULSE);
        check_output("mid-reset width1", width_of(1), CENTER_PULSE);
        step_cycles(2);
        Reset = 1'b1;
        wait_frame_start("re-release");
        exp_q.push_back(exp_t'{20, 20});

        for (int i = 15; i < vecs.size(); i++) apply_stimulus(vecs[i], $sformatf("v%0d", i));
        measure_frame("final");
        check_output("scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
